// File: rtl/dac_i2s_tx.sv
// I2S master transmitter for the TLV320 DAC: derives BCLK/LRCLK from the system clock and shifts
// stereo samples MSB-first, one BCLK after each LRCLK edge, with a one-pair holding buffer.
module dac_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_data,
  output logic                  underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] DW_CNT   = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_nxt;
  logic [CNT_W-1:0]      slot_pos;
  logic [IDX_W-1:0]      bit_idx;
  logic                  slot_is_right;
  logic                  fall_event;
  logic                  frame_load;
  logic                  accept;
  logic                  next_bit;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [DATA_WIDTH-1:0] frame_left;
  logic [DATA_WIDTH-1:0] frame_right;

  // in_ready is kept free of any in_valid dependence so the producer never sees a combinational loop
  assign in_ready = ~hold_full & reset_n;

  always_comb begin
    fall_event    = (div_cnt == DIV_LAST) && i2s_bclk;
    bit_cnt_nxt   = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + ONE_CNT;
    slot_is_right = (bit_cnt_nxt >= SLOT_LEN);
    slot_pos      = slot_is_right ? bit_cnt_nxt - SLOT_LEN : bit_cnt_nxt;
    frame_load    = fall_event && (bit_cnt_nxt == '0);
    accept        = in_valid && in_ready;
    bit_idx       = IDX_W'(DW_CNT - slot_pos);
    next_bit      = 1'b0;
    // Slot position 0 is the one-BCLK I2S delay; positions past the sample width pad with zeros
    if ((slot_pos >= ONE_CNT) && (slot_pos <= DW_CNT)) begin
      next_bit = slot_is_right ? frame_right[bit_idx] : frame_left[bit_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      i2s_bclk    <= 1'b0;
      bit_cnt     <= CNT_LAST;
      i2s_lrclk   <= 1'b1;
      i2s_data    <= 1'b0;
      hold_full   <= 1'b0;
      hold_left   <= '0;
      hold_right  <= '0;
      frame_left  <= '0;
      frame_right <= '0;
      underrun    <= 1'b0;
    end else begin
      underrun <= 1'b0;

      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // Everything the codec samples moves on the BCLK falling edge
      if (fall_event) begin
        bit_cnt   <= bit_cnt_nxt;
        i2s_lrclk <= slot_is_right;
        i2s_data  <= next_bit;
      end

      if (frame_load) begin
        if (hold_full) begin
          frame_left  <= hold_left;
          frame_right <= hold_right;
        end else begin
          frame_left  <= '0;
          frame_right <= '0;
          underrun    <= 1'b1;
        end
      end

      // An accept can only coincide with a load when the buffer was already empty
      if (accept) begin
        hold_left  <= left_data;
        hold_right <= right_data;
        hold_full  <= 1'b1;
      end else if (frame_load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
